// File: rtl/avst_pkt_pkg.sv
// avst_pkt_pkg: shared types, constants and parameter check for the Avalon-ST packetizer
package avst_pkt_pkg;

    localparam logic [15:0] SYNC_WORD = 16'hA5C3;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    typedef struct packed {
        logic [15:0] sync;
        logic [7:0]  seq;
        logic [7:0]  len_m1;
    } hdr_t;

    function automatic bit check_params(input int data_width, input int pkt_len);
        return data_width >= 32 && pkt_len >= 1 && pkt_len <= 256;
    endfunction

endpackage

// File: rtl/avst_out_reg.sv
// avst_out_reg: single-entry output register with valid/ready slot tracking
module avst_out_reg
    import avst_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_sop,
    input  logic                  ld_eop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  slot_free
);

    assign slot_free = !out_valid || out_ready;

    // a load in the same cycle as a drain keeps out_valid high
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_sop   <= ld_sop;
            out_eop   <= ld_eop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/avst_packetizer.sv
// avst_packetizer: frames the FIFO word stream into header + PKT_LEN payload Avalon-ST packets
module avst_packetizer
    import avst_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [15:0]           pkt_count
);

    localparam logic [7:0] LEN_M1 = 8'(PKT_LEN - 1);

    if (!check_params(DATA_WIDTH, PKT_LEN)) begin : g_bad_params
        $fatal(1, "avst_packetizer: DATA_WIDTH must be >= 32 and PKT_LEN in 1..256");
    end

    state_t                state, state_n;
    logic [7:0]            cnt, seq;
    logic                  slot_free, load, ld_sop, ld_eop, last;
    logic [DATA_WIDTH-1:0] ld_data;
    hdr_t                  hdr;

    assign hdr  = '{sync: SYNC_WORD, seq: seq, len_m1: LEN_M1};
    assign last = cnt == LEN_M1;

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        in_ready = 1'b0;
        ld_sop   = 1'b0;
        ld_eop   = 1'b0;
        ld_data  = in_data;
        case (state)
            IDLE:    state_n = in_valid ? HEADER : IDLE;
            HEADER: begin
                load    = slot_free;
                ld_sop  = 1'b1;
                ld_data = DATA_WIDTH'(hdr);
                state_n = slot_free ? PAYLOAD : HEADER;
            end
            PAYLOAD: begin
                in_ready = slot_free;
                load     = in_valid && slot_free;
                ld_eop   = last;
                state_n  = (load && last) ? IDLE : PAYLOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            seq       <= '0;
            pkt_count <= '0;
        end else begin
            state <= state_n;
            if (load) cnt <= ld_sop ? '0 : cnt + 8'd1;
            if (load && ld_eop) seq <= seq + 8'd1;
            if (out_valid && out_ready && out_eop) pkt_count <= pkt_count + 16'd1;
        end
    end

    avst_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk       (clk),
        .aresetn   (aresetn),
        .load      (load),
        .ld_data   (ld_data),
        .ld_sop    (ld_sop),
        .ld_eop    (ld_eop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_avst_packetizer.sv
// tb_avst_packetizer: directed scoreboard bench for avst_packetizer with PKT_LEN=4
module tb_avst_packetizer;

    localparam int DW = 32;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_sop, out_eop;
    logic [DW-1:0] out_data;
    logic [15:0]   pkt_count;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t       q[$];
    beat_t       held, exp_b;
    logic        held_v = 1'b0;
    logic [7:0]  mseq = '0;
    int          checks = 0, errors = 0, beats = 0, cyc = 0;
    int          sop_cyc = 0, eop_cyc = 0, eop_cyc_prev = 0, t0 = 0, b0 = 0;

    avst_packetizer #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: scoreboard pops on each handshake, hold check while stalled
    always @(negedge clk) begin
        if (aresetn) begin
            if (held_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_beat", 64'({out_data, out_sop, out_eop}), 64'(held));
            end
            if (out_valid && !out_ready) begin
                chk("in_ready_bp", 64'(in_ready), 64'd0);
                held   = {out_data, out_sop, out_eop};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", out_data);
                end
                if (q.size() > 0) begin
                    exp_b = q.pop_front();
                    chk("beat", 64'({out_data, out_sop, out_eop}), 64'(exp_b));
                end
                beats++;
                if (out_sop) sop_cyc = cyc;
                if (out_eop) begin
                    eop_cyc_prev = eop_cyc;
                    eop_cyc      = cyc;
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (in_ready) else begin
            errors++;
            $error("FAIL accept_timeout observed=%0d expected=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pkt(input logic [DW-1:0] base, input int gap);
        q.push_back({DW'({16'hA5C3, mseq, 8'(PL - 1)}), 1'b1, 1'b0});
        mseq++;
        for (int i = 0; i < PL; i++) q.push_back({base + DW'(i), 1'b0, i == PL - 1});
        for (int i = 0; i < PL; i++) send_word(base + DW'(i), gap);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_sop"}, 64'(out_sop), 64'd0);
        chk({tag, "_out_eop"}, 64'(out_eop), 64'd0);
        chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        aresetn = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // single packet, header latency 2 cycles after in_valid
        t0 = cyc;
        send_pkt(32'd1, 0);
        drain();
        chk("hdr_latency", 64'(sop_cyc - t0), 64'd2);
        chk("pkt_count_1", 64'(pkt_count), 64'd1);

        // two back-to-back packets at PKT_LEN+2 cycles each
        b0 = beats;
        send_pkt(32'h10, 0);
        send_pkt(32'h20, 0);
        drain();
        chk("b2b_beats", 64'(beats - b0), 64'd10);
        chk("b2b_period", 64'(eop_cyc - eop_cyc_prev), 64'(PL + 2));
        chk("pkt_count_3", 64'(pkt_count), 64'd3);

        // 5-cycle downstream stall mid-payload
        b0 = beats;
        fork
            send_pkt(32'h30, 0);
            begin
                int n = 0;
                while (beats < b0 + 3 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("pkt_count_4", 64'(pkt_count), 64'd4);

        // input gaps: 1 on, 2 off
        send_pkt(32'h40, 2);
        drain();
        chk("pkt_count_5", 64'(pkt_count), 64'd5);

        // abandon a packet after header + 2 payload words via reset
        q.push_back({DW'({16'hA5C3, mseq, 8'(PL - 1)}), 1'b1, 1'b0});
        q.push_back({32'h50, 1'b0, 1'b0});
        q.push_back({32'h51, 1'b0, 1'b0});
        send_word(32'h50, 0);
        send_word(32'h51, 0);
        drain();
        #2;
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        mseq = '0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        send_pkt(32'h100, 0);
        drain();
        chk("post_reset_count", 64'(pkt_count), 64'd1);

        // 256 more packets: the last header carries seq 0 again
        for (int p = 0; p < 256; p++) send_pkt(32'h1000 + DW'(p * 16), 0);
        drain();
        chk("seq_wrap_model", 64'(mseq), 64'd1);
        chk("pkt_count_257", 64'(pkt_count), 64'd257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
